// File: rtl/mmu_hs_pkg.sv
// Shared types for the MMU handshake fabric: wait-merge FSM states and port limit.
package mmu_hs_pkg;

  localparam int unsigned MAX_PORTS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StWaitFree,
    StRelease
  } wm_state_e;

endpackage

// File: rtl/wait_merge_n_mmu_if.sv
// Handshake bundle between upstream ports, the N-way wait-merge and its downstream.
interface wait_merge_n_mmu_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TMO_W     = 8
);

  logic [NUM_PORTS-1:0]        i_mask;
  logic [NUM_PORTS-1:0]        i_drive;
  logic [NUM_PORTS*DATA_W-1:0] i_data;
  logic [NUM_PORTS-1:0]        o_free;
  logic                        o_driveNext;
  logic [NUM_PORTS*DATA_W-1:0] o_data;
  logic                        i_freeNext;
  logic                        o_err;
  logic [TMO_W-1:0]            i_tmo_thr;
  logic                        o_tmo;

  modport master (
    output i_mask, i_drive, i_data, i_freeNext, i_tmo_thr,
    input  o_free, o_driveNext, o_data, o_err, o_tmo
  );

  modport slave (
    input  i_mask, i_drive, i_data, i_freeNext, i_tmo_thr,
    output o_free, o_driveNext, o_data, o_err, o_tmo
  );

endinterface

// File: rtl/wait_merge_slot_mmu.sv
// One input port of the wait-merge: pending flag, captured payload and misuse detection.
module wait_merge_slot_mmu #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              drive_i,
  input  logic              en_i,        // port participates and the FSM can accept now
  input  logic              pend_ign_i,  // pending is being cleared this cycle
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pend_o,
  output logic              acc_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o
);

  logic              pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    acc_o  = drive_i & en_i & (pend_ign_i | ~pend_q);
    err_o  = drive_i & ~acc_o;
    pend_d = pend_q;
    data_d = data_q;
    // A new arrival outranks the clear so a drive in the release cycle is kept.
    if (acc_o) begin
      pend_d = 1'b1;
      data_d = data_i;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign pend_o = pend_q;
  assign data_o = data_q;

endmodule

// File: rtl/wait_merge_n_mmu.sv
// N-way wait-merge: joins per-port drive tokens into one merged downstream token.
// Optional partial-round timeout enabled by defining WAIT_MERGE_TIMEOUT_EN.
module wait_merge_n_mmu
  import mmu_hs_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TMO_W     = 8
) (
  input logic                clk,
  input logic                rstn,
  wait_merge_n_mmu_if.slave  bus
);

  wm_state_e            state_q, state_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 err_q, err_d;
  logic [NUM_PORTS-1:0] pend, acc, slot_err, en, mask_eff, free;
  logic [DATA_W-1:0]    slot_data [NUM_PORTS];
  logic                 round_start, pend_ign, clr_pend, complete, tmo_hit, drive_next;

  // A round opens on the first drive with nothing pending, or on a drive during release.
  assign round_start = (|bus.i_drive) &&
                       ((state_q == StIdle && pend == '0) || state_q == StRelease);
  assign mask_eff    = round_start ? bus.i_mask : mask_q;
  assign en          = (state_q inside {StIdle, StRelease}) ? mask_eff : '0;
  assign pend_ign    = (state_q == StRelease);
  assign clr_pend    = (state_q == StRelease) || tmo_hit;
  assign complete    = (state_q == StIdle) && (mask_eff != '0) &&
                       (((pend | acc) & mask_eff) == mask_eff);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
    wait_merge_slot_mmu #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .drive_i   (bus.i_drive[k]),
      .en_i      (en[k]),
      .pend_ign_i(pend_ign),
      .clr_i     (clr_pend),
      .data_i    (bus.i_data[k*DATA_W +: DATA_W]),
      .pend_o    (pend[k]),
      .acc_o     (acc[k]),
      .err_o     (slot_err[k]),
      .data_o    (slot_data[k])
    );
    assign bus.o_data[k*DATA_W +: DATA_W] = mask_q[k] ? slot_data[k] : '0;
  end

`ifdef WAIT_MERGE_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  // The accepting cycle counts as the first cycle of the wait.
  assign tmo_hit = (state_q == StIdle) && (pend != '0) && (bus.i_tmo_thr != '0) &&
                   (acc == '0) && (cnt_q == bus.i_tmo_thr);

  always_comb begin
    cnt_d = '0;
    if (tmo_hit) begin
      cnt_d = '0;
    end else if (acc != '0) begin
      cnt_d = TMO_W'(1);
    end else if (state_q == StIdle && pend != '0) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tmo_thr;
  assign unused_tmo_thr = ^bus.i_tmo_thr;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    drive_next = 1'b0;
    free       = '0;
    if (round_start) begin
      mask_d = bus.i_mask;
    end
    case (state_q)
      StIdle: begin
        if (complete) begin
          state_d = StFire;
        end else if (tmo_hit) begin
          free   = pend;
          mask_d = '0;
        end
      end
      StFire: begin
        drive_next = 1'b1;
        state_d    = StWaitFree;
      end
      StWaitFree: begin
        if (bus.i_freeNext) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        free    = mask_q;
        state_d = StIdle;
        if (!round_start) begin
          mask_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_d = err_q | (|slot_err) | (bus.i_freeNext && state_q != StWaitFree) | tmo_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_driveNext = drive_next;
  assign bus.o_free      = free;
  assign bus.o_err       = err_q;
  assign bus.o_tmo       = tmo_hit;

endmodule

// File: tb/tb_wait_merge_n_mmu.sv
// Directed bench for wait_merge_n_mmu (N=4); exercises the timeout path when
// WAIT_MERGE_TIMEOUT_EN is defined.
module tb_wait_merge_n_mmu;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;

  localparam logic [31:0] D0 = 32'h1000_00A0;
  localparam logic [31:0] D1 = 32'h2000_00B1;
  localparam logic [31:0] D2 = 32'h3000_00C2;
  localparam logic [31:0] D3 = 32'h4000_00D3;
  localparam logic [127:0] BASE = {D3, D2, D1, D0};

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  wait_merge_n_mmu_if #(.NUM_PORTS(NP), .DATA_W(DW), .TMO_W(TW)) bus ();

  wait_merge_n_mmu #(
    .NUM_PORTS(NP),
    .DATA_W   (DW),
    .TMO_W    (TW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic         r_dn, r_err, r_tmo;
  logic [3:0]   r_free;
  logic [127:0] r_data;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, sample outputs mid-cycle, drop pulses after the edge.
  task automatic step(input logic [3:0] drv, input logic fn, input logic [3:0] msk);
    bus.i_drive    = drv;
    bus.i_freeNext = fn;
    bus.i_mask     = msk;
    @(negedge clk);
    r_dn   = bus.o_driveNext;
    r_free = bus.o_free;
    r_data = bus.o_data;
    r_err  = bus.o_err;
    r_tmo  = bus.o_tmo;
    @(posedge clk);
    #1;
    bus.i_drive    = '0;
    bus.i_freeNext = 1'b0;
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    bus.i_drive    = '0;
    bus.i_freeNext = 1'b0;
    bus.i_mask     = '0;
    bus.i_data     = BASE;
    bus.i_tmo_thr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int           fire_c, fire2_c, n_fire, free_c, n_free, tmo_c;
  logic [3:0]   drv, free_v;
  logic [127:0] dat, dat2;
  logic         err_a;

  initial begin
    // Reset values
    rstn = 1'b0;
    bus.i_drive = '0; bus.i_freeNext = 1'b0; bus.i_mask = '0;
    bus.i_data = BASE; bus.i_tmo_thr = '0;
    @(negedge clk);
    check_eq("rst_free", bus.o_free, 4'h0);
    check_eq("rst_dn", bus.o_driveNext, 1'b0);
    check_eq("rst_data", bus.o_data, 128'h0);
    check_eq("rst_err", bus.o_err, 1'b0);
    check_eq("rst_tmo", bus.o_tmo, 1'b0);

    // Staggered drives 1,3,4,6 -> fire at 7; free at 10 -> release at 11
    do_reset();
    fire_c = -1; n_fire = 0; free_c = -1; free_v = '0; dat = '0;
    for (int c = 0; c < 15; c++) begin
      drv = (c == 1) ? 4'b0001 : (c == 3) ? 4'b0010 : (c == 4) ? 4'b0100 :
            (c == 6) ? 4'b1000 : 4'b0000;
      step(drv, c == 10, 4'hF);
      if (r_dn) begin n_fire++; if (fire_c < 0) begin fire_c = c; dat = r_data; end end
      if (r_free != 0 && free_c < 0) begin free_c = c; free_v = r_free; end
    end
    check_eq("t1_fire_cycle", fire_c, 7);
    check_eq("t1_fire_count", n_fire, 1);
    check_eq("t1_data", dat, BASE);
    check_eq("t1_free_cycle", free_c, 11);
    check_eq("t1_free_val", free_v, 4'hF);
    check_eq("t1_err", r_err, 1'b0);

    // All drives at cycle 2 -> fire 3; freeNext 6 -> o_free=F only at 7
    do_reset();
    fire_c = -1; free_c = -1; n_free = 0; free_v = '0;
    for (int c = 0; c < 11; c++) begin
      step((c == 2) ? 4'hF : 4'h0, c == 6, 4'hF);
      if (r_dn && fire_c < 0) fire_c = c;
      if (r_free != 0) begin n_free++; if (free_c < 0) begin free_c = c; free_v = r_free; end end
    end
    check_eq("t2_fire_cycle", fire_c, 3);
    check_eq("t2_free_cycle", free_c, 7);
    check_eq("t2_free_val", free_v, 4'hF);
    check_eq("t2_free_count", n_free, 1);

    // mask 0101: masked-out drive on port 1 flags error, slice 1 reads 0
    do_reset();
    fire_c = -1; err_a = 1'b0; dat = '0;
    for (int c = 0; c < 6; c++) begin
      drv = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0101 : 4'b0000;
      step(drv, 1'b0, 4'b0101);
      if (c == 1) err_a = r_err;
      if (r_dn && fire_c < 0) begin fire_c = c; dat = r_data; end
    end
    check_eq("t3_err", err_a, 1'b1);
    check_eq("t3_fire_cycle", fire_c, 2);
    check_eq("t3_data", dat, {32'h0, D2, 32'h0, D0});

    // Port 0 driven twice: second ignored, first payload kept
    do_reset();
    fire_c = -1; dat = '0; err_a = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.i_data = (c == 0) ? {D3, D2, D1, 32'hDEAD_0001} :
                   (c == 1) ? {D3, D2, D1, 32'hBEEF_0002} : BASE;
      drv = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0001 : (c == 2) ? 4'b1110 : 4'b0000;
      step(drv, 1'b0, 4'hF);
      if (c == 2) err_a = r_err;
      if (r_dn && fire_c < 0) begin fire_c = c; dat = r_data; end
    end
    check_eq("t4_err", err_a, 1'b1);
    check_eq("t4_fire_cycle", fire_c, 3);
    check_eq("t4_data", dat, {D3, D2, D1, 32'hDEAD_0001});

    // Drive on port 2 in release cycle opens next round with mask 0100
    do_reset();
    fire_c = -1; fire2_c = -1; free_c = -1; free_v = '0; dat2 = '0;
    for (int c = 0; c < 9; c++) begin
      drv = (c == 0) ? 4'hF : (c == 3) ? 4'b0100 : 4'b0000;
      step(drv, c == 2, (c == 3) ? 4'b0100 : 4'hF);
      if (r_dn) begin
        if (fire_c < 0) fire_c = c;
        else if (fire2_c < 0) begin fire2_c = c; dat2 = r_data; end
      end
      if (r_free != 0 && free_c < 0) begin free_c = c; free_v = r_free; end
    end
    check_eq("t5_fire1", fire_c, 1);
    check_eq("t5_free_cycle", free_c, 3);
    check_eq("t5_free_val", free_v, 4'hF);
    check_eq("t5_fire2", fire2_c, 5);
    check_eq("t5_data2", dat2, {32'h0, D2, 32'h0, 32'h0});
    check_eq("t5_err", r_err, 1'b0);

    // freeNext outside WAIT_FREE raises sticky error
    do_reset();
    step(4'h0, 1'b1, 4'hF);
    check_eq("t6_err_before", r_err, 1'b0);
    step(4'h0, 1'b0, 4'hF);
    check_eq("t6_err_after", r_err, 1'b1);

    // All-zero mask at round start: error, no fire
    do_reset();
    n_fire = 0;
    for (int c = 0; c < 6; c++) begin
      step((c == 0) ? 4'b0001 : 4'b0000, 1'b0, 4'h0);
      if (r_dn) n_fire++;
    end
    check_eq("t7_fire_count", n_fire, 0);
    check_eq("t7_err", r_err, 1'b1);

    // Partial round: ports 0,1 at cycle 0, threshold 10
    do_reset();
    bus.i_tmo_thr = 8'd10;
    tmo_c = -1; free_v = '0; n_fire = 0; n_free = 0;
    for (int c = 0; c < 15; c++) begin
      step((c == 0) ? 4'b0011 : 4'b0000, 1'b0, 4'hF);
      if (r_dn) n_fire++;
      if (r_free != 0) n_free++;
      if (r_tmo && tmo_c < 0) begin tmo_c = c; free_v = r_free; end
    end
    check_eq("t8_fire_count", n_fire, 0);
`ifdef WAIT_MERGE_TIMEOUT_EN
    check_eq("t8_tmo_cycle", tmo_c, 10);
    check_eq("t8_tmo_free", free_v, 4'b0011);
    check_eq("t8_free_count", n_free, 1);
    check_eq("t8_err", r_err, 1'b1);
`else
    check_eq("t8_tmo_cycle", tmo_c, -1);
    check_eq("t8_free_count", n_free, 0);
    check_eq("t8_err", r_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
